fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and hazard unit for the pipelined core.
- Sits beside the ID stage. It keeps its own shadow of destination registers for EX/MEM/WB and forwards the youngest ready producer value to every ID read port.
- Generates the load-use stall, and the multi-cycle stall for long-latency EX ops such as mul/div.
- The pipeline supplies decoded producer kind and per-stage write-back values, so no opcode decoding happens here.

---
 rtl/fwd_pkg.sv | 51 +++++
 rtl/fwd_hazard_unit_if.sv | 41 ++++
 rtl/fwd_port_sel.sv | 64 ++++++
 rtl/fwd_hazard_unit.sv | 103 ++++++++++
 tb/tb_fwd_hazard_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared types for the forwarding / hazard unit:
//   - producer kind encodings (how late a result becomes available)
//   - forward source encodings driven on fwd_src
//   - shadow entry tracked for each of EX, MEM and WB
//   - readiness function: can a given stage forward its value this cycle
// No ports (package).
// -----------------------------------------------------------------------------
package fwd_pkg;

    typedef enum logic [1:0] {
        KIND_ALU  = 2'b00,  // result ready in EX
        KIND_LOAD = 2'b01,  // result ready in MEM
        KIND_LONG = 2'b10   // result ready in EX after LONG_LAT cycles
    } kind_e;

    typedef enum logic [1:0] {
        SRC_RF  = 2'b00,
        SRC_EX  = 2'b01,
        SRC_MEM = 2'b10,
        SRC_WB  = 2'b11
    } src_e;

    typedef enum logic [1:0] {
        STG_EX  = 2'b00,
        STG_MEM = 2'b01,
        STG_WB  = 2'b10
    } stage_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        kind_e      kind;
    } shadow_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // A LONG op only leaves EX once its occupancy has expired, so by MEM its
    // value is as final as an ALU or LOAD result.
    function automatic logic entry_ready(kind_e kind, stage_e stg, logic cnt_zero);
        logic rdy;
        case (stg)
            STG_EX:  rdy = (kind == KIND_ALU) || ((kind == KIND_LONG) && cnt_zero);
            STG_MEM: rdy = (kind == KIND_ALU) || (kind == KIND_LOAD) || (kind == KIND_LONG);
            default: rdy = 1'b1;
        endcase
        return rdy;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit_if
// Bundle between the ID stage of the pipeline and the forwarding/hazard unit.
//   master (pipeline): drives ID instruction info, flush, RF read data and the
//                      per-stage write-back values; receives stall, ex_hold
//                      and the forwarded operands.
//   slave  (unit)    : the reverse.
// Read port p uses id_rs[5p+4:5p], fwd_src[2p+1:2p], *_data[XLEN*p +: XLEN].
// -----------------------------------------------------------------------------
interface fwd_hazard_unit_if #(
    parameter int XLEN   = 32,
    parameter int NUM_RD = 2
);
    logic                     id_valid;
    logic [NUM_RD*5-1:0]      id_rs;
    logic [NUM_RD-1:0]        id_rs_used;
    logic [4:0]               id_rd;
    logic                     id_we;
    logic [1:0]               id_kind;
    logic                     flush;
    logic [NUM_RD*XLEN-1:0]   rf_rdata;
    logic [XLEN-1:0]          ex_result;
    logic [XLEN-1:0]          mem_result;
    logic [XLEN-1:0]          wb_result;
    logic                     stall;
    logic                     ex_hold;
    logic [NUM_RD*2-1:0]      fwd_src;
    logic [NUM_RD*XLEN-1:0]   fwd_data;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_we, id_kind, flush,
               rf_rdata, ex_result, mem_result, wb_result,
        input  stall, ex_hold, fwd_src, fwd_data
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_we, id_kind, flush,
               rf_rdata, ex_result, mem_result, wb_result,
        output stall, ex_hold, fwd_src, fwd_data
    );
endinterface

// File: rtl/fwd_port_sel.sv
// -----------------------------------------------------------------------------
// fwd_port_sel
// One ID read port: matches its source register against the EX/MEM/WB shadow
// entries (youngest first), selects the forward source and operand value, and
// flags a hazard when the youngest producer is not ready yet.
//   rs, rs_used                  : register index and "port really reads"
//   ex_ent, mem_ent, wb_ent      : shadow entries per stage
//   cnt_zero                     : long-op counter in EX has expired
//   rf_data, *_result            : candidate operand values
//   src, data, hazard            : selected source, operand, hazard flag
// -----------------------------------------------------------------------------
module fwd_port_sel
    import fwd_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs,
    input  logic            rs_used,
    input  shadow_t         ex_ent,
    input  shadow_t         mem_ent,
    input  shadow_t         wb_ent,
    input  logic            cnt_zero,
    input  logic [XLEN-1:0] rf_data,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] mem_result,
    input  logic [XLEN-1:0] wb_result,
    output logic [1:0]      src,
    output logic [XLEN-1:0] data,
    output logic            hazard
);

    // The youngest matching stage decides alone: if it is not ready the port
    // waits rather than picking up a stale value from an older stage.
    always_comb begin
        src    = SRC_RF;
        data   = rf_data;
        hazard = 1'b0;
        if (rs_used && (rs != REG_X0)) begin
            if (ex_ent.valid && (ex_ent.rd == rs)) begin
                if (entry_ready(ex_ent.kind, STG_EX, cnt_zero)) begin
                    src  = SRC_EX;
                    data = ex_result;
                end else begin
                    hazard = 1'b1;
                end
            end else if (mem_ent.valid && (mem_ent.rd == rs)) begin
                if (entry_ready(mem_ent.kind, STG_MEM, cnt_zero)) begin
                    src  = SRC_MEM;
                    data = mem_result;
                end else begin
                    hazard = 1'b1;
                end
            end else if (wb_ent.valid && (wb_ent.rd == rs)) begin
                if (entry_ready(wb_ent.kind, STG_WB, cnt_zero)) begin
                    src  = SRC_WB;
                    data = wb_result;
                end else begin
                    hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
// Forwarding and hazard unit beside the ID stage. Shadows the destination
// registers in EX/MEM/WB, forwards the youngest ready producer to every ID
// read port, and generates the load-use stall and the long-op EX hold.
//   cpu_clk, cpu_rst : clock, asynchronous active-high reset
//   bus (slave)      : ID info, flush, RF data and stage results in;
//                      stall, ex_hold, fwd_src, fwd_data out (combinational)
// -----------------------------------------------------------------------------
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_RD   = 2,
    parameter int LONG_LAT = 4
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    fwd_hazard_unit_if.slave bus
);

    localparam int              CNT_W    = $clog2(LONG_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LONG_LAT - 1);

    shadow_t           ex_ent_p0;
    shadow_t           mem_ent_p1;
    shadow_t           wb_ent_p2;
    shadow_t           id_ent;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_zero;
    logic              ex_hold;
    logic              stall;
    logic              issue;
    logic              issue_long;
    logic [NUM_RD-1:0] port_hazard;

    // x0 is never tracked, and neither is an instruction that does not write.
    always_comb begin
        id_ent.valid = bus.id_we && (bus.id_rd != REG_X0);
        id_ent.rd    = bus.id_rd;
        id_ent.kind  = kind_e'(bus.id_kind);
    end

    assign cnt_zero   = (cnt == '0);
    assign ex_hold    = ex_ent_p0.valid && (ex_ent_p0.kind == KIND_LONG) && !cnt_zero;
    assign stall      = ex_hold || (bus.id_valid && (|port_hazard));
    assign issue      = bus.id_valid && !stall && !bus.flush;
    assign issue_long = issue && (kind_e'(bus.id_kind) == KIND_LONG);

    assign bus.stall   = stall;
    assign bus.ex_hold = ex_hold;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic [1:0]      src;
        logic [XLEN-1:0] data;

        fwd_port_sel #(.XLEN(XLEN)) u_sel (
            .rs         (bus.id_rs[5*p +: 5]),
            .rs_used    (bus.id_rs_used[p]),
            .ex_ent     (ex_ent_p0),
            .mem_ent    (mem_ent_p1),
            .wb_ent     (wb_ent_p2),
            .cnt_zero   (cnt_zero),
            .rf_data    (bus.rf_rdata[XLEN*p +: XLEN]),
            .ex_result  (bus.ex_result),
            .mem_result (bus.mem_result),
            .wb_result  (bus.wb_result),
            .src        (src),
            .data       (data),
            .hazard     (port_hazard[p])
        );

        assign bus.fwd_src[2*p +: 2]        = src;
        assign bus.fwd_data[XLEN*p +: XLEN] = data;
    end

    // ID -> EX(p0) -> MEM(p1) -> WB(p2). While a long op holds EX, MEM takes
    // bubbles and WB keeps draining; a flushed or stalled ID becomes a bubble.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            ex_ent_p0  <= '0;
            mem_ent_p1 <= '0;
            wb_ent_p2  <= '0;
            cnt        <= '0;
        end else if (ex_hold) begin
            cnt        <= cnt - CNT_W'(1);
            mem_ent_p1 <= '0;
            wb_ent_p2  <= mem_ent_p1;
        end else begin
            if (issue) begin
                ex_ent_p0 <= id_ent;
            end else begin
                ex_ent_p0 <= '0;
            end
            mem_ent_p1 <= ex_ent_p0;
            wb_ent_p2  <= mem_ent_p1;
            if (issue_long) begin
                cnt <= CNT_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
    import fwd_pkg::*;

    localparam logic [31:0] RF0 = 32'h0000_F0F0;
    localparam logic [31:0] RF1 = 32'h0000_F1F1;

    typedef struct packed {
        logic       r;
        logic       v;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
        logic [4:0] rd;
        logic       we;
        logic [1:0] kind;
        logic       fl;
    } stim_t;

    typedef struct packed {
        logic        stall;
        logic        hold;
        logic [3:0]  src;
        logic [63:0] data;
    } obs_t;

    logic cpu_clk;
    logic cpu_rst;
    int   n_run;
    int   n_fail;
    obs_t exp_q[$];

    fwd_hazard_unit_if #(.XLEN(32), .NUM_RD(2)) ifc ();
    fwd_hazard_unit_if #(.XLEN(32), .NUM_RD(2)) ifc1 ();

    fwd_hazard_unit #(.XLEN(32), .NUM_RD(2), .LONG_LAT(4)) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .bus     (ifc.slave)
    );

    fwd_hazard_unit #(.XLEN(32), .NUM_RD(2), .LONG_LAT(1)) dut_lat1 (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .bus     (ifc1.slave)
    );

    assign ifc1.id_valid   = ifc.id_valid;
    assign ifc1.id_rs      = ifc.id_rs;
    assign ifc1.id_rs_used = ifc.id_rs_used;
    assign ifc1.id_rd      = ifc.id_rd;
    assign ifc1.id_we      = ifc.id_we;
    assign ifc1.id_kind    = ifc.id_kind;
    assign ifc1.flush      = ifc.flush;
    assign ifc1.rf_rdata   = ifc.rf_rdata;
    assign ifc1.ex_result  = ifc.ex_result;
    assign ifc1.mem_result = ifc.mem_result;
    assign ifc1.wb_result  = ifc.wb_result;

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    function automatic stim_t st(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                                 input logic [1:0] used, input logic [4:0] rd, input logic we,
                                 input logic [1:0] kind, input logic fl = 1'b0, input logic r = 1'b0);
        stim_t s;
        s.r = r; s.v = v; s.rs0 = rs0; s.rs1 = rs1; s.used = used;
        s.rd = rd; s.we = we; s.kind = kind; s.fl = fl;
        return s;
    endfunction

    function automatic obs_t mk(input logic stall, input logic hold, input logic [1:0] s1,
                                input logic [1:0] s0, input logic [31:0] d1, input logic [31:0] d0);
        obs_t o;
        o.stall = stall; o.hold = hold; o.src = {s1, s0}; o.data = {d1, d0};
        return o;
    endfunction

    function automatic obs_t obs_main();
        obs_t o;
        o.stall = ifc.stall; o.hold = ifc.ex_hold; o.src = ifc.fwd_src; o.data = ifc.fwd_data;
        return o;
    endfunction

    function automatic obs_t obs_lat1();
        obs_t o;
        o.stall = ifc1.stall; o.hold = ifc1.ex_hold; o.src = ifc1.fwd_src; o.data = ifc1.fwd_data;
        return o;
    endfunction

    task automatic drive(input stim_t s);
        cpu_rst        = s.r;
        ifc.id_valid   = s.v;
        ifc.id_rs      = {s.rs1, s.rs0};
        ifc.id_rs_used = s.used;
        ifc.id_rd      = s.rd;
        ifc.id_we      = s.we;
        ifc.id_kind    = s.kind;
        ifc.flush      = s.fl;
    endtask

    task automatic set_results(input logic [31:0] ex, input logic [31:0] mem, input logic [31:0] wb);
        ifc.ex_result  = ex;
        ifc.mem_result = mem;
        ifc.wb_result  = wb;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge cpu_clk); #1;
            drive(st(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, KIND_ALU));
        end
    endtask

    task automatic test_reset();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, exp;
        set_results(32'h1, 32'h2, 32'h3);
        s.push_back(st(1, 5, 6, 2'b11, 5, 1, KIND_LONG, 0, 1)); e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        s.push_back(st(1, 5, 6, 2'b11, 5, 1, KIND_LONG, 0, 1)); e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        s.push_back(st(0, 5, 6, 2'b11, 0, 0, KIND_ALU));        e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        s.push_back(st(1, 5, 0, 2'b01, 0, 0, KIND_ALU));        e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        foreach (s[i]) begin
            @(posedge cpu_clk); #1;
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge cpu_clk);
            got = obs_main();
            exp = exp_q.pop_front();
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset row %0d: got stall=%b hold=%b src=%h data=%h, expected stall=%b hold=%b src=%h data=%h",
                         i, got.stall, got.hold, got.src, got.data, exp.stall, exp.hold, exp.src, exp.data);
            end
        end
        idle(4);
    endtask

    task automatic test_alu_chain();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, exp;
        set_results(32'h11, 32'h22, 32'h33);
        s.push_back(st(1, 0, 0, 2'b00, 5, 1, KIND_ALU)); e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        s.push_back(st(1, 5, 9, 2'b11, 0, 0, KIND_ALU)); e.push_back(mk(0, 0, 0, 1, RF1, 32'h11));
        s.push_back(st(1, 5, 5, 2'b10, 0, 0, KIND_ALU)); e.push_back(mk(0, 0, 2, 0, 32'h22, RF0));
        s.push_back(st(1, 5, 9, 2'b11, 0, 0, KIND_ALU)); e.push_back(mk(0, 0, 0, 3, RF1, 32'h33));
        s.push_back(st(1, 5, 9, 2'b11, 0, 0, KIND_ALU)); e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        foreach (s[i]) begin
            @(posedge cpu_clk); #1;
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge cpu_clk);
            got = obs_main();
            exp = exp_q.pop_front();
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL alu_chain row %0d: got stall=%b hold=%b src=%h data=%h, expected stall=%b hold=%b src=%h data=%h",
                         i, got.stall, got.hold, got.src, got.data, exp.stall, exp.hold, exp.src, exp.data);
            end
        end
        idle(4);
    endtask

    task automatic test_load_use();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, exp;
        set_results(32'h55, 32'hDEADBEEF, 32'h66);
        s.push_back(st(1, 0, 0, 2'b00, 6, 1, KIND_LOAD)); e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        s.push_back(st(1, 0, 6, 2'b10, 0, 0, KIND_ALU));  e.push_back(mk(1, 0, 0, 0, RF1, RF0));
        s.push_back(st(1, 0, 6, 2'b10, 0, 0, KIND_ALU));  e.push_back(mk(0, 0, 2, 0, 32'hDEADBEEF, RF0));
        s.push_back(st(0, 0, 6, 2'b10, 0, 0, KIND_ALU));  e.push_back(mk(0, 0, 3, 0, 32'h66, RF0));
        s.push_back(st(1, 0, 0, 2'b00, 6, 1, KIND_LOAD)); e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        s.push_back(st(0, 0, 6, 2'b10, 0, 0, KIND_ALU));  e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        foreach (s[i]) begin
            @(posedge cpu_clk); #1;
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge cpu_clk);
            got = obs_main();
            exp = exp_q.pop_front();
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL load_use row %0d: got stall=%b hold=%b src=%h data=%h, expected stall=%b hold=%b src=%h data=%h",
                         i, got.stall, got.hold, got.src, got.data, exp.stall, exp.hold, exp.src, exp.data);
            end
        end
        idle(4);
    endtask

    task automatic test_priority();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, exp;
        set_results(32'hA, 32'hB, 32'hC);
        s.push_back(st(1, 0, 0, 2'b00, 7, 1, KIND_ALU)); e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        s.push_back(st(1, 0, 0, 2'b00, 7, 1, KIND_ALU)); e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        s.push_back(st(1, 0, 0, 2'b00, 7, 1, KIND_ALU)); e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        s.push_back(st(1, 7, 7, 2'b11, 0, 0, KIND_ALU)); e.push_back(mk(0, 0, 1, 1, 32'hA, 32'hA));
        s.push_back(st(1, 0, 7, 2'b10, 0, 1, KIND_ALU)); e.push_back(mk(0, 0, 2, 0, 32'hB, RF0));
        s.push_back(st(1, 0, 7, 2'b11, 0, 0, KIND_ALU)); e.push_back(mk(0, 0, 3, 0, 32'hC, RF0));
        foreach (s[i]) begin
            @(posedge cpu_clk); #1;
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge cpu_clk);
            got = obs_main();
            exp = exp_q.pop_front();
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL priority row %0d: got stall=%b hold=%b src=%h data=%h, expected stall=%b hold=%b src=%h data=%h",
                         i, got.stall, got.hold, got.src, got.data, exp.stall, exp.hold, exp.src, exp.data);
            end
        end
        idle(4);
    endtask

    task automatic test_long_op();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, exp;
        set_results(32'h44, 32'h45, 32'h46);
        s.push_back(st(1, 0, 0, 2'b00, 9, 1, KIND_ALU));  e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        s.push_back(st(1, 0, 9, 2'b10, 8, 1, KIND_LONG)); e.push_back(mk(0, 0, 1, 0, 32'h44, RF0));
        s.push_back(st(1, 8, 9, 2'b11, 0, 0, KIND_ALU));  e.push_back(mk(1, 1, 2, 0, 32'h45, RF0));
        s.push_back(st(1, 8, 9, 2'b11, 0, 0, KIND_ALU));  e.push_back(mk(1, 1, 3, 0, 32'h46, RF0));
        s.push_back(st(1, 8, 9, 2'b11, 0, 0, KIND_ALU));  e.push_back(mk(1, 1, 0, 0, RF1, RF0));
        s.push_back(st(1, 8, 9, 2'b11, 0, 0, KIND_ALU));  e.push_back(mk(0, 0, 0, 1, RF1, 32'h44));
        foreach (s[i]) begin
            @(posedge cpu_clk); #1;
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge cpu_clk);
            got = obs_main();
            exp = exp_q.pop_front();
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL long_op row %0d: got stall=%b hold=%b src=%h data=%h, expected stall=%b hold=%b src=%h data=%h",
                         i, got.stall, got.hold, got.src, got.data, exp.stall, exp.hold, exp.src, exp.data);
            end
        end
        idle(6);
    endtask

    task automatic test_flush();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, exp;
        set_results(32'h50, 32'h51, 32'h52);
        s.push_back(st(1, 0, 0, 2'b00, 11, 1, KIND_ALU, 1)); e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        s.push_back(st(1, 11, 0, 2'b01, 0, 0, KIND_ALU));    e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        s.push_back(st(1, 0, 0, 2'b00, 8, 1, KIND_LONG));    e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        s.push_back(st(1, 8, 0, 2'b01, 0, 0, KIND_ALU));     e.push_back(mk(1, 1, 0, 0, RF1, RF0));
        s.push_back(st(1, 0, 0, 2'b00, 10, 1, KIND_ALU, 1)); e.push_back(mk(1, 1, 0, 0, RF1, RF0));
        s.push_back(st(0, 0, 10, 2'b10, 0, 0, KIND_ALU));    e.push_back(mk(1, 1, 0, 0, RF1, RF0));
        s.push_back(st(1, 8, 10, 2'b11, 0, 0, KIND_ALU));    e.push_back(mk(0, 0, 0, 1, RF1, 32'h50));
        s.push_back(st(1, 0, 10, 2'b10, 0, 0, KIND_ALU));    e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        foreach (s[i]) begin
            @(posedge cpu_clk); #1;
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge cpu_clk);
            got = obs_main();
            exp = exp_q.pop_front();
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL flush row %0d: got stall=%b hold=%b src=%h data=%h, expected stall=%b hold=%b src=%h data=%h",
                         i, got.stall, got.hold, got.src, got.data, exp.stall, exp.hold, exp.src, exp.data);
            end
        end
        idle(6);
    endtask

    task automatic test_reset_mid_long();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, exp;
        set_results(32'h70, 32'h71, 32'h72);
        s.push_back(st(1, 0, 0, 2'b00, 8, 1, KIND_LONG));      e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        s.push_back(st(1, 8, 0, 2'b01, 0, 0, KIND_ALU));       e.push_back(mk(1, 1, 0, 0, RF1, RF0));
        s.push_back(st(1, 8, 0, 2'b01, 0, 0, KIND_ALU, 0, 1)); e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        s.push_back(st(1, 8, 0, 2'b01, 0, 0, KIND_ALU));       e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        s.push_back(st(1, 8, 0, 2'b01, 0, 0, KIND_ALU));       e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        foreach (s[i]) begin
            @(posedge cpu_clk); #1;
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge cpu_clk);
            got = obs_main();
            exp = exp_q.pop_front();
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_long row %0d: got stall=%b hold=%b src=%h data=%h, expected stall=%b hold=%b src=%h data=%h",
                         i, got.stall, got.hold, got.src, got.data, exp.stall, exp.hold, exp.src, exp.data);
            end
        end
        idle(4);
    endtask

    task automatic test_long_lat1();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, exp;
        set_results(32'h90, 32'h91, 32'h92);
        s.push_back(st(1, 0, 0, 2'b00, 8, 1, KIND_LONG)); e.push_back(mk(0, 0, 0, 0, RF1, RF0));
        s.push_back(st(1, 8, 0, 2'b01, 0, 0, KIND_ALU));  e.push_back(mk(0, 0, 0, 1, RF1, 32'h90));
        foreach (s[i]) begin
            @(posedge cpu_clk); #1;
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge cpu_clk);
            got = obs_lat1();
            exp = exp_q.pop_front();
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL long_lat1 row %0d: got stall=%b hold=%b src=%h data=%h, expected stall=%b hold=%b src=%h data=%h",
                         i, got.stall, got.hold, got.src, got.data, exp.stall, exp.hold, exp.src, exp.data);
            end
        end
        idle(6);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test by 100000 time units, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_run          = 0;
        n_fail         = 0;
        cpu_rst        = 1'b0;
        ifc.id_valid   = 1'b0;
        ifc.id_rs      = '0;
        ifc.id_rs_used = '0;
        ifc.id_rd      = '0;
        ifc.id_we      = 1'b0;
        ifc.id_kind    = 2'b00;
        ifc.flush      = 1'b0;
        ifc.rf_rdata   = {RF1, RF0};
        set_results(32'h0, 32'h0, 32'h0);
        #1 cpu_rst = 1'b1;

        test_reset();
        test_alu_chain();
        test_load_use();
        test_priority();
        test_long_op();
        test_flush();
        test_reset_mid_long();
        test_long_lat1();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
